// File: rtl/ram_if.sv
// Control bundle for the single-port SRAM-style RAM: chip select, write
// enable, output enable and word address. The shared data bus is a
// bidirectional net and is carried as a separate inout port on the RAM.
interface ram_if #(
    parameter int ADDR_WIDTH = 14
);
    logic                  cs;
    logic                  we;
    logic                  oe;
    logic [ADDR_WIDTH-1:0] addr;

    // Bus master (CPU, datapath or testbench) drives the controls.
    modport master (output cs, output we, output oe, output addr);

    // The RAM only observes the controls.
    modport slave (input cs, input we, input oe, input addr);
endinterface : ram_if

// File: rtl/ram.sv
// Single-port synchronous word RAM with a classic SRAM-style interface
// (cs/we/oe) and a shared bidirectional data bus. Writes are synchronous.
// Reads pass through a one-cycle output register that is driven onto the bus
// only while cs && oe && !we and the block is out of reset.
module ram #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_if.slave                  bus,
    inout  wire  [DATA_WIDTH-1:0] data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] rd_d;
    logic                  wr_en;
    logic                  rd_en;
    logic                  drive_en;

    // Decode the SRAM controls; a write always takes priority over oe.
    always_comb begin
        wr_en    = bus.cs && bus.we;
        rd_en    = bus.cs && !bus.we;
        drive_en = bus.cs && bus.oe && !bus.we && rst_n;
    end

    // Storage write port: the word on the bus is captured at the clock edge.
    // NOTE: the array has no reset branch so it maps onto block RAM; contents
    // survive rst_n, and qualifying on rst_n suppresses a write on a reset edge.
    // NOTE: non-blocking update means a read on the following edge sees the
    // new word, while a read in the same time step still sees the old one.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem[bus.addr] <= data;
        end
    end

    // Next read word: fetch on any selected non-write cycle so the data is
    // ready before oe rises; otherwise hold the last word.
    always_comb begin
        rd_d = rd_q;
        if (rd_en) begin
            rd_d = mem[bus.addr];
        end
    end

    // Output register, cleared asynchronously so the bus never carries stale
    // data immediately after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    // Tri-state bus driver: enable is combinational so the bus releases in
    // the same cycle the controls drop; never driven while we is high.
    assign data = drive_en ? rd_q : {DATA_WIDTH{1'bz}};

endmodule : ram

// File: tb/tb_ram.sv
// Directed self-checking bench for the SRAM-style RAM. Expected words come
// from hand-picked constants and from a local copy of the random words the
// bench itself wrote. Bus release is probed by having the bench drive a
// known zero pattern: if the RAM also drives, the bus no longer reads zero.
module tb_ram;

    localparam int AW = 14;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          tb_drv;
    logic [DW-1:0] tb_val;
    wire  [DW-1:0] data;

    int n_tests;
    int n_fail;

    logic [DW-1:0] words [0:19];

    ram_if #(.ADDR_WIDTH(AW)) bus_if ();

    ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave),
        .data  (data)
    );

    assign data = tb_drv ? tb_val : {DW{1'bz}};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one write cycle from a falling edge; returns at the next falling edge.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] v, input logic oe_v);
        bus_if.cs   = 1'b1;
        bus_if.we   = 1'b1;
        bus_if.oe   = oe_v;
        bus_if.addr = a;
        tb_drv      = 1'b1;
        tb_val      = v;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present a read address, then check the bus one clock later.
    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
        tb_drv      = 1'b0;
        bus_if.cs   = 1'b1;
        bus_if.we   = 1'b0;
        bus_if.oe   = 1'b1;
        bus_if.addr = a;
        @(posedge clk);
        @(negedge clk);
        check(tag, data, exp);
    endtask

    // Park the RAM controls and have the bench drive zero onto the bus.
    task automatic probe_zero(input logic cs_v, input logic we_v, input logic oe_v);
        bus_if.cs = cs_v;
        bus_if.we = we_v;
        bus_if.oe = oe_v;
        tb_drv    = 1'b1;
        tb_val    = '0;
        #1;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        bus_if.cs   = 1'b1;
        bus_if.we   = 1'b0;
        bus_if.oe   = 1'b1;
        bus_if.addr = '0;
        tb_drv      = 1'b1;
        tb_val      = '0;

        // Reset with read controls active: RAM must not drive.
        repeat (3) @(negedge clk);
        check("reset_bus_released", data, 32'h0);

        // Release between edges: unwritten address, oe=1 shows cleared rd_q.
        tb_drv      = 1'b0;
        bus_if.addr = 14'h0123;
        rst_n       = 1'b1;
        #1;
        check("post_reset_rd_zero", data, 32'h0);
        @(negedge clk);

        // Write 0..19 with random words, then read them back-to-back.
        for (int i = 0; i < 20; i++) begin
            words[i] = $urandom;
            do_write(AW'(i), words[i], 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            do_read(AW'(i), words[i], $sformatf("readback_%0d", i));
        end

        // Boundary addresses, no aliasing between first and last word.
        do_write(14'h0000, 32'hDEADBEEF, 1'b0);
        do_write(14'h3FFF, 32'hCAFEF00D, 1'b0);
        do_read(14'h0000, 32'hDEADBEEF, "boundary_low");
        do_read(14'h3FFF, 32'hCAFEF00D, "boundary_high");

        // Bus ownership: rd_q now holds a non-zero word.
        probe_zero(1'b0, 1'b0, 1'b1);
        check("own_cs_low", data, 32'h0);
        probe_zero(1'b1, 1'b0, 1'b0);
        check("own_oe_low", data, 32'h0);
        probe_zero(1'b1, 1'b1, 1'b0);
        check("own_we_high", data, 32'h0);
        @(negedge clk);

        // we and oe together: bench owns the bus and the write lands.
        bus_if.cs   = 1'b1;
        bus_if.we   = 1'b1;
        bus_if.oe   = 1'b1;
        bus_if.addr = 14'd100;
        tb_drv      = 1'b1;
        tb_val      = 32'h5A5A1234;
        #1;
        check("own_we_oe_bus", data, 32'h5A5A1234);
        @(posedge clk);
        @(negedge clk);
        do_read(14'd100, 32'h5A5A1234, "we_oe_write_lands");

        // Read-after-write on the very next cycle.
        do_write(14'd5, 32'h12345678, 1'b0);
        do_read(14'd5, 32'h12345678, "read_after_write");

        // Mid-operation reset on a write edge to addr 7.
        do_write(14'd7, 32'hA5A5A5A5, 1'b0);
        do_read(14'd7, 32'hA5A5A5A5, "addr7_before_reset");
        bus_if.cs   = 1'b1;
        bus_if.we   = 1'b1;
        bus_if.oe   = 1'b0;
        bus_if.addr = 14'd7;
        tb_drv      = 1'b1;
        tb_val      = 32'h0BADF00D;
        rst_n       = 1'b0;
        @(posedge clk);
        @(negedge clk);
        probe_zero(1'b1, 1'b0, 1'b1);
        check("midreset_bus_released", data, 32'h0);
        tb_drv = 1'b0;
        rst_n  = 1'b1;
        #1;
        check("midreset_rd_cleared", data, 32'h0);
        @(negedge clk);
        do_read(14'd7, 32'hA5A5A5A5, "midreset_write_suppressed");

        bus_if.cs = 1'b0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ram
